// File: rtl/io_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_pkg                                                           |
// | Shared constants and helpers for the memory-mapped I/O block.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package io_pkg;

    localparam logic [31:0] IO_BASE = 32'h1000_0000;
    localparam int          HEX_W   = 7;
    localparam int          N_HEX   = 8;

    // Register select taken from addr[15:12]
    localparam logic [3:0] OFF_LEDR   = 4'h0;
    localparam logic [3:0] OFF_LEDG   = 4'h1;
    localparam logic [3:0] OFF_HEX_LO = 4'h2;
    localparam logic [3:0] OFF_HEX_HI = 4'h3;
    localparam logic [3:0] OFF_LCD    = 4'h4;
    localparam logic [3:0] OFF_SW     = 4'h8;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] cur,
        input logic [31:0] upd,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) res[8*k +: 8] = upd[8*k +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_sync                                                          |
// | N-stage flip-flop synchronizer with asynchronous clear.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module io_sync
    import io_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int WIDTH  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/io_output_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_output_buffer                                                 |
// | Memory-mapped LED/HEX/LCD output registers and switch readback.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module io_output_buffer
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = IO_BASE,
    parameter int          SW_SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_lsu_addr,
    input  logic [31:0]      i_st_data,
    input  logic             i_lsu_wren,
    input  logic [3:0]       i_bmask,
    input  logic [31:0]      i_io_sw,
    output logic [31:0]      o_ld_data,
    output logic             o_io_hit,
    output logic [31:0]      o_io_ledr,
    output logic [31:0]      o_io_ledg,
    output logic [31:0]      o_io_lcd,
    output logic [HEX_W-1:0] o_io_hex0,
    output logic [HEX_W-1:0] o_io_hex1,
    output logic [HEX_W-1:0] o_io_hex2,
    output logic [HEX_W-1:0] o_io_hex3,
    output logic [HEX_W-1:0] o_io_hex4,
    output logic [HEX_W-1:0] o_io_hex5,
    output logic [HEX_W-1:0] o_io_hex6,
    output logic [HEX_W-1:0] o_io_hex7
);

    logic [31:0]      r_ledr;
    logic [31:0]      r_ledg;
    logic [31:0]      r_lcd;
    logic [HEX_W-1:0] r_hex [N_HEX];

    logic             w_hit;
    logic [3:0]       w_off;
    logic             w_wr;
    logic [31:0]      w_sw;
    logic [31:0]      w_ld_data;
    logic             w_unused_addr;

    assign w_hit = (i_lsu_addr[31:16] == BASE_ADDR[31:16]);
    assign w_off = i_lsu_addr[15:12];
    assign w_wr  = i_lsu_wren & w_hit;
    // Word offset bits only alias registers inside a 4 KiB window.
    assign w_unused_addr = ^i_lsu_addr[11:0];

    io_sync #(
        .STAGES (SW_SYNC_STAGES),
        .WIDTH  (32)
    ) u_sw_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_io_sw),
        .o_q     (w_sw)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ledr <= '0;
            r_ledg <= '0;
            r_lcd  <= '0;
            for (int k = 0; k < N_HEX; k++) r_hex[k] <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_LEDR: r_ledr <= lane_merge(r_ledr, i_st_data, i_bmask);
                OFF_LEDG: r_ledg <= lane_merge(r_ledg, i_st_data, i_bmask);
                OFF_LCD:  r_lcd  <= lane_merge(r_lcd,  i_st_data, i_bmask);
                OFF_HEX_LO: begin
                    for (int k = 0; k < 4; k++) begin
                        if (i_bmask[k]) r_hex[k] <= i_st_data[8*k +: HEX_W];
                    end
                end
                OFF_HEX_HI: begin
                    for (int k = 0; k < 4; k++) begin
                        if (i_bmask[k]) r_hex[k+4] <= i_st_data[8*k +: HEX_W];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ld_data = '0;
        if (w_hit) begin
            case (w_off)
                OFF_LEDR:   w_ld_data = r_ledr;
                OFF_LEDG:   w_ld_data = r_ledg;
                OFF_LCD:    w_ld_data = r_lcd;
                OFF_HEX_LO: w_ld_data = {1'b0, r_hex[3], 1'b0, r_hex[2],
                                         1'b0, r_hex[1], 1'b0, r_hex[0]};
                OFF_HEX_HI: w_ld_data = {1'b0, r_hex[7], 1'b0, r_hex[6],
                                         1'b0, r_hex[5], 1'b0, r_hex[4]};
                OFF_SW:     w_ld_data = w_sw;
                default:    w_ld_data = '0;
            endcase
        end
    end

    assign o_ld_data = w_ld_data;
    assign o_io_hit  = w_hit;
    assign o_io_ledr = r_ledr;
    assign o_io_ledg = r_ledg;
    assign o_io_lcd  = r_lcd;
    assign o_io_hex0 = r_hex[0];
    assign o_io_hex1 = r_hex[1];
    assign o_io_hex2 = r_hex[2];
    assign o_io_hex3 = r_hex[3];
    assign o_io_hex4 = r_hex[4];
    assign o_io_hex5 = r_hex[5];
    assign o_io_hex6 = r_hex[6];
    assign o_io_hex7 = r_hex[7];

endmodule
`default_nettype wire

// File: tb/tb_io_output_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_io_output_buffer                                              |
// | Scoreboard bench for the memory-mapped I/O output buffer.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_io_output_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_lsu_addr, i_st_data, i_io_sw;
    logic        i_lsu_wren;
    logic [3:0]  i_bmask;
    logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
    logic        o_io_hit;
    logic [6:0]  w_hex [8];

    always #5 clk = ~clk;

    io_output_buffer #(
        .BASE_ADDR      (32'h1000_0000),
        .SW_SYNC_STAGES (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_lsu_addr (i_lsu_addr),
        .i_st_data  (i_st_data),
        .i_lsu_wren (i_lsu_wren),
        .i_bmask    (i_bmask),
        .i_io_sw    (i_io_sw),
        .o_ld_data  (o_ld_data),
        .o_io_hit   (o_io_hit),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_lcd   (o_io_lcd),
        .o_io_hex0  (w_hex[0]),
        .o_io_hex1  (w_hex[1]),
        .o_io_hex2  (w_hex[2]),
        .o_io_hex3  (w_hex[3]),
        .o_io_hex4  (w_hex[4]),
        .o_io_hex5  (w_hex[5]),
        .o_io_hex6  (w_hex[6]),
        .o_io_hex7  (w_hex[7])
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state
    logic [31:0] m_ledr, m_ledg, m_lcd, m_sw1, m_sw2;
    logic [6:0]  m_hex [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sw1 <= '0;
            m_sw2 <= '0;
        end else begin
            m_sw1 <= i_io_sw;
            m_sw2 <= m_sw1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string sel_name(input int sel);
        case (sel)
            0:  return "ledr";
            1:  return "ledg";
            2:  return "lcd";
            11: return "ld_data";
            12: return "io_hit";
            default: return $sformatf("hex%0d", sel - 3);
        endcase
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:  return o_io_ledr;
            1:  return o_io_ledg;
            2:  return o_io_lcd;
            11: return o_ld_data;
            12: return {31'b0, o_io_hit};
            default: return {25'b0, w_hex[sel-3]};
        endcase
    endfunction

    function automatic logic [31:0] model_out(input int sel);
        case (sel)
            0:  return m_ledr;
            1:  return m_ledg;
            2:  return m_lcd;
            default: return {25'b0, m_hex[sel-3]};
        endcase
    endfunction

    function automatic logic model_hit(input logic [31:0] addr);
        return addr[31:16] == 16'h1000;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr);
        if (!model_hit(addr)) return 32'h0;
        case (addr[15:12])
            4'h0: return m_ledr;
            4'h1: return m_ledg;
            4'h2: return {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
            4'h3: return {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]};
            4'h4: return m_lcd;
            4'h8: return m_sw2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        if (rst || !model_hit(addr)) return;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                case (addr[15:12])
                    4'h0: m_ledr[8*k +: 8] = data[8*k +: 8];
                    4'h1: m_ledg[8*k +: 8] = data[8*k +: 8];
                    4'h2: m_hex[k]         = data[8*k +: 7];
                    4'h3: m_hex[k+4]       = data[8*k +: 7];
                    4'h4: m_lcd[8*k +: 8]  = data[8*k +: 8];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_clear();
        m_ledr = '0;
        m_ledg = '0;
        m_lcd  = '0;
        for (int k = 0; k < 8; k++) m_hex[k] = '0;
    endtask

    task automatic push(input int sel, input logic [31:0] exp);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_all();
        for (int s = 0; s <= 10; s++) push(s, model_out(s));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(sel_name(e.sel), observe(e.sel), e.exp);
        end
    endtask

    task automatic check_load(input logic [31:0] addr);
        i_lsu_addr = addr;
        #1;
        push(11, model_load(addr));
        push(12, {31'b0, model_hit(addr)});
        drain();
    endtask

    // Load result is checked before the edge so it shows the pre-store value.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        i_lsu_addr = addr;
        i_st_data  = data;
        i_bmask    = mask;
        i_lsu_wren = 1'b1;
        #1;
        push(11, model_load(addr));
        push(12, {31'b0, model_hit(addr)});
        drain();
        @(posedge clk);
        model_store(addr, data, mask);
        #1;
        i_lsu_wren = 1'b0;
        i_bmask    = 4'h0;
        push_all();
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        i_lsu_addr = '0;
        i_st_data  = '0;
        i_lsu_wren = 1'b0;
        i_bmask    = 4'h0;
        i_io_sw    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        push_all();
        drain();
        check_load(32'h1000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_store(32'h1000_0000, 32'h0000_0001, 4'b1111);
        check_load(32'h1000_0000);
        check_load(32'h1000_0FFC);

        do_store(32'h1000_1000, 32'hAABB_CCDD, 4'b1111);
        do_store(32'h1000_1000, 32'h0000_1100, 4'b0010);
        push(1, 32'hAABB_11DD);
        drain();
        check_load(32'h1000_1004);

        do_store(32'h1000_2000, 32'hFFFF_FFFF, 4'b1111);
        push(11, 32'h7F7F_7F7F);
        i_lsu_addr = 32'h1000_2000;
        #1;
        drain();
        do_store(32'h1000_3000, 32'h1234_5678, 4'b0101);
        check_load(32'h1000_3000);
        do_store(32'h1000_0000, 32'hFFFF_FFFF, 4'b0000);

        // Switch readback through the synchronizer
        @(negedge clk);
        i_io_sw    = 32'h0000_00A5;
        i_lsu_addr = 32'h1000_8000;
        @(posedge clk);
        #1;
        push(11, 32'h0);
        drain();
        @(posedge clk);
        #1;
        push(11, 32'h0000_00A5);
        drain();
        check_load(32'h1000_8000);
        do_store(32'h1000_8000, 32'h0000_1234, 4'b1111);
        check_load(32'h1000_8000);

        do_store(32'h2000_0000, 32'h0000_0005, 4'b1111);
        check_load(32'h1001_0000);
        do_store(32'h1000_7000, 32'hDEAD_BEEF, 4'b1111);
        check_load(32'h1000_7000);

        do_store(32'h1000_4000, 32'h8000_0041, 4'b1111);
        check_load(32'h1000_4000);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        push_all();
        drain();
        check_load(32'h1000_4000);
        check_load(32'h1000_8000);

        do_store(32'h1000_0000, 32'h0000_DEAD, 4'b1111);
        #1;
        rst = 1'b0;
        do_store(32'h1000_0000, 32'h0000_0055, 4'b1111);
        check_load(32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
